mem_port_arbiter: RTL and testbench

- Arbitrates the single unified instruction/data memory between two requesters:
  - the fetch stage (IF);
  - the load/store stage (MEM).
- Serialises accesses so that a single-ported RAM can replace the dual-access array in the pipelined core.
- Gives data accesses priority, with a starvation guard for fetch.
- Supports a configurable read latency and a branch flush that cancels an in-flight fetch return.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port.
// AW/DW defaults match the core's memory interface.
package mips_mem_pkg;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned MEM_DW = 32;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto one single-ported RAM.
// Data wins arbitration; fetch wins once after STARVE_MAX consecutive losses.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW         = MEM_AW,
  parameter int unsigned DW         = MEM_DW,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          flush,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [2:0]  latCnt_q, latCnt_d;
  logic [3:0]  starveCnt_q, starveCnt_d;
  logic        cancel_q, cancel_d;
  logic        ifRvalid_q, dRvalid_q;
  logic [DW-1:0] ifRdata_q, dRdata_q;
  logic        ifWin, dWin, readGrant, cancelNow, ifCapture, dCapture;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    ifWin = 1'b0;
    dWin  = 1'b0;
    if (rst_n && state_q == IDLE) begin
      ifWin = if_req && (!d_req || starveCnt_q == STARVE_LIM);
      dWin  = !ifWin && d_req;
    end
    readGrant = ifWin || (dWin && !d_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      latCnt_q    <= '0;
      starveCnt_q <= '0;
      cancel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      latCnt_q    <= latCnt_d;
      starveCnt_q <= starveCnt_d;
      cancel_q    <= cancel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    latCnt_d    = latCnt_q;
    starveCnt_d = starveCnt_q;
    cancel_d    = cancel_q;
    cancelNow   = cancel_q;
    ifCapture   = 1'b0;
    dCapture    = 1'b0;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (ifWin || !if_req)
          starveCnt_d = '0;
        else if (dWin && starveCnt_q != STARVE_LIM)
          starveCnt_d = starveCnt_q + 4'd1;
        if (readGrant) begin
          state_d  = RD_WAIT;
          latCnt_d = LAT_INIT;
          owner_d  = ifWin ? OWN_IF : OWN_D;
          cancel_d = ifWin && flush;
        end
      end
      RD_WAIT: begin
        latCnt_d  = latCnt_q - 3'd1;
        cancelNow = cancel_q || (owner_q == OWN_IF && flush);
        cancel_d  = cancelNow;
        // A flush arriving in the return cycle still suppresses the fetch data.
        if (latCnt_q == 3'd1) begin
          state_d   = IDLE;
          cancel_d  = 1'b0;
          ifCapture = (owner_q == OWN_IF) && !cancelNow;
          dCapture  = (owner_q == OWN_D);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifRvalid_q <= 1'b0;
      dRvalid_q  <= 1'b0;
      ifRdata_q  <= '0;
      dRdata_q   <= '0;
    end else begin
      ifRvalid_q <= ifCapture;
      dRvalid_q  <= dCapture;
      if (ifCapture) ifRdata_q <= mem_rdata;
      if (dCapture)  dRdata_q  <= mem_rdata;
    end
  end

  always_comb begin
    if_gnt    = ifWin;
    d_gnt     = dWin;
    mem_en    = ifWin || dWin;
    mem_we    = dWin && d_we;
    mem_addr  = dWin ? d_addr : if_addr;
    mem_wdata = d_wdata;
    busy      = (state_q == RD_WAIT);
    if_rvalid = ifRvalid_q;
    d_rvalid  = dRvalid_q;
    if_rdata  = ifRdata_q;
    d_rdata   = dRdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-accurate RAM model.
// Read data is queued when a grant is seen and checked when rvalid pulses.
module tb_mem_port_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req, d_req, d_we, flush;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int totalCount = 0;
  int badCount   = 0;

  logic [DW-1:0] ifQ[$];
  logic [DW-1:0] dQ[$];
  logic [DW-1:0] refMem [0:1023];
  logic [DW-1:0] ram    [0:1023];
  logic [DW-1:0] pipe   [0:LAT-1];
  logic          ramLoaded = 1'b0;
  logic [DW-1:0] ifExp, dExp;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .flush(flush),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  function automatic logic [DW-1:0] seedWord(input int i);
    if (i == 5)  return 32'h8C22_0000;
    if (i == 30) return 32'h0000_0011;
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // RAM model: read data appears LAT cycles after the mem_en cycle, zero otherwise.
  always @(posedge clk) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= seedWord(i);
      ramLoaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : '0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    if (obs !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [AW-1:0] ifAddr,
                               input logic dReq, input logic dWe, input logic [AW-1:0] dAddr,
                               input logic [DW-1:0] dWdata, input logic fl);
    @(posedge clk);
    #1;
    if_req  = ifReq;
    if_addr = ifAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_addr  = dAddr;
    d_wdata = dWdata;
    flush   = fl;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Scoreboard: every rvalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (ifQ.size() == 0) checkOutput("ifSpurious", if_rvalid, 0);
      else begin
        ifExp = ifQ.pop_front();
        checkOutput("ifRdata", if_rdata, ifExp);
      end
    end
    if (d_rvalid) begin
      if (dQ.size() == 0) checkOutput("dSpurious", d_rvalid, 0);
      else begin
        dExp = dQ.pop_front();
        checkOutput("dRdata", d_rdata, dExp);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dGrants;
    int issued;
    int cyc;
    bit ifGranted;
    bit expG;

    for (int i = 0; i < 1024; i++) refMem[i] = seedWord(i);
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; flush = 0;

    // Reset: outputs idle even with both requests raised
    repeat (2) @(posedge clk);
    @(negedge clk);
    if_req = 1; d_req = 1;
    #1;
    checkOutput("rstIfGnt", if_gnt, 0);
    checkOutput("rstDGnt", d_gnt, 0);
    checkOutput("rstMemEn", mem_en, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstIfRvalid", if_rvalid, 0);
    checkOutput("rstDRdata", d_rdata, 0);
    if_req = 0; d_req = 0;
    @(negedge clk);
    rst_n = 1;

    // Single fetch read
    applyStimulus(1, 10'd5, 0, 0, '0, '0, 0);
    checkOutput("t1IfGnt", if_gnt, 1);
    checkOutput("t1MemEn", mem_en, 1);
    checkOutput("t1MemWe", mem_we, 0);
    checkOutput("t1MemAddr", mem_addr, 5);
    ifQ.push_back(refMem[5]);
    for (int k = 1; k <= LAT; k++) begin
      idleCycle();
      checkOutput("t1Busy", busy, 1);
      checkOutput("t1RvalidEarly", if_rvalid, 0);
    end
    idleCycle();
    checkOutput("t1Rvalid", if_rvalid, 1);
    checkOutput("t1BusyDone", busy, 0);

    // Store and fetch together: store first, fetch next cycle
    applyStimulus(1, 10'd6, 1, 1, 10'd20, 32'hDEAD_BEEF, 0);
    checkOutput("t2DGnt", d_gnt, 1);
    checkOutput("t2IfGntLose", if_gnt, 0);
    checkOutput("t2MemWe", mem_we, 1);
    checkOutput("t2MemAddr", mem_addr, 20);
    checkOutput("t2MemWdata", mem_wdata, 32'hDEAD_BEEF);
    refMem[20] = 32'hDEAD_BEEF;
    applyStimulus(1, 10'd6, 0, 0, '0, '0, 0);
    checkOutput("t2IfGnt", if_gnt, 1);
    checkOutput("t2FetchAddr", mem_addr, 6);
    ifQ.push_back(refMem[6]);
    repeat (LAT + 1) idleCycle();
    checkOutput("t2RamWord", ram[20], refMem[20]);

    // Starvation guard: data wins SMAX times, then fetch wins once
    dGrants = 0; ifGranted = 0; cyc = 0;
    while (!ifGranted && cyc < 60) begin
      applyStimulus(1, 10'd7, 1, 0, AW'(40 + dGrants), '0, 0);
      if (d_gnt) begin
        dQ.push_back(refMem[40 + dGrants]);
        dGrants++;
      end
      if (if_gnt) begin
        ifQ.push_back(refMem[7]);
        ifGranted = 1;
      end
      cyc++;
    end
    checkOutput("t3IfWon", ifGranted, 1);
    checkOutput("t3DataWins", dGrants, SMAX);
    cyc = 0;
    do begin
      applyStimulus(1, 10'd12, 1, 0, 10'd50, '0, 0);
      cyc++;
    end while (!d_gnt && !if_gnt && cyc < 20);
    checkOutput("t3StarveClrD", d_gnt, 1);
    checkOutput("t3StarveClrIf", if_gnt, 0);
    if (d_gnt) dQ.push_back(refMem[50]);
    if (if_gnt) ifQ.push_back(refMem[12]);
    repeat (LAT + 1) idleCycle();

    // Flush while the fetch is outstanding cancels its return
    applyStimulus(1, 10'd8, 0, 0, '0, '0, 0);
    checkOutput("t4IfGnt", if_gnt, 1);
    applyStimulus(0, '0, 0, 0, '0, '0, 1);
    for (int k = 2; k <= LAT; k++) begin
      idleCycle();
      checkOutput("t4NoRvalidMid", if_rvalid, 0);
    end
    applyStimulus(0, '0, 1, 0, 10'd31, '0, 0);
    checkOutput("t4NoRvalid", if_rvalid, 0);
    checkOutput("t4NextGnt", d_gnt, 1);
    dQ.push_back(refMem[31]);
    // Flush has no effect on a data read
    for (int k = 1; k <= LAT; k++) applyStimulus(0, '0, 0, 0, '0, '0, 1);
    idleCycle();
    checkOutput("t4DataRvalid", d_rvalid, 1);

    // Flush in the grant cycle also cancels
    applyStimulus(1, 10'd9, 0, 0, '0, '0, 1);
    checkOutput("t4bIfGnt", if_gnt, 1);
    repeat (LAT) idleCycle();
    idleCycle();
    checkOutput("t4bNoRvalid", if_rvalid, 0);
    checkOutput("t4bIdle", busy, 0);

    // Reset in the middle of a data read
    applyStimulus(0, '0, 1, 0, 10'd30, '0, 0);
    checkOutput("t5DGnt", d_gnt, 1);
    @(posedge clk);
    #2;
    rst_n = 0;
    d_req = 1;
    #1;
    checkOutput("t5Busy", busy, 0);
    checkOutput("t5DGntRst", d_gnt, 0);
    checkOutput("t5MemEn", mem_en, 0);
    checkOutput("t5DRdata", d_rdata, 0);
    checkOutput("t5IfRdata", if_rdata, 0);
    @(negedge clk);
    rst_n = 1;
    d_req = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      idleCycle();
      checkOutput("t5NoRvalid", d_rvalid, 0);
    end
    applyStimulus(1, 10'd13, 0, 0, '0, '0, 0);
    checkOutput("t5PostGnt", if_gnt, 1);
    ifQ.push_back(refMem[13]);
    repeat (LAT + 1) idleCycle();

    // Back-to-back fetches: each new grant coincides with the previous rvalid
    issued = 0;
    for (int c = 0; c <= 3 * (LAT + 1); c++) begin
      applyStimulus(issued < 3, AW'(9 + issued), 0, 0, '0, '0, 0);
      expG = (c % (LAT + 1) == 0) && (c < 3 * (LAT + 1));
      checkOutput("t6Gnt", if_gnt, expG);
      checkOutput("t6Rvalid", if_rvalid, (c > 0) && (c % (LAT + 1) == 0));
      if (if_gnt) begin
        ifQ.push_back(refMem[9 + issued]);
        issued++;
      end
    end
    idleCycle();

    checkOutput("ifQDrained", ifQ.size(), 0);
    checkOutput("dQDrained", dQ.size(), 0);
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
